// File: rtl/spi_slave_regs.sv
// ---------------------------------------------------------------------------
// spi_slave_regs
//   SPI mode-3 responder in front of a byte-wide register file. First byte of
//   every transfer is a command: bit7 = R/W (1 = read), bit6 = MS (address
//   auto-increment), bits5:0 = register address. Following bytes are read or
//   written data. All SPI pins are oversampled in the clk domain, so sck must
//   run at least 8x slower than clk.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   csn, sck, mosi      SPI inputs (raw, asynchronous to clk)
//   miso, miso_oe       SPI data out and its enable for an external tristate
//   upd_en/addr/data    local fabric write port into the register file
//   wr_strobe/addr/data one-cycle report of each completed SPI write byte
//
// Build option
//   SPI_REGS_WHOAMI_EN  when defined, address 0x0F is read-only and always
//                       returns WHOAMI_VAL; otherwise it is a normal register.
// ---------------------------------------------------------------------------
module spi_slave_regs #(
  parameter int unsigned DEPTH      = 64,
  parameter logic [7:0]  WHOAMI_VAL = 8'h33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csn,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       upd_en,
  input  logic [5:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data
);

`ifdef SPI_REGS_WHOAMI_EN
  localparam bit WHOAMI_EN = 1'b1;
`else
  localparam bit WHOAMI_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  // Input synchronizers and sck edge detection
  logic       csn_s1_q, csn_s2_q;
  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [1:0] vld_q;

  logic csn_sync, sync_vld, sck_rise, sck_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_s1_q   <= 1'b1;
      csn_s2_q   <= 1'b1;
      sck_s1_q   <= 1'b1;
      sck_s2_q   <= 1'b1;
      sck_prev_q <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      vld_q      <= '0;
    end else begin
      csn_s1_q   <= csn;
      csn_s2_q   <= csn_s1_q;
      sck_s1_q   <= sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      mosi_s1_q  <= mosi;
      mosi_s2_q  <= mosi_s1_q;
      vld_q      <= {vld_q[0], 1'b1};
    end
  end

  assign csn_sync = csn_s2_q;
  // The csn synchronizer holds its reset value for two cycles; it only
  // reflects the pin once both stages have been loaded from it.
  assign sync_vld = vld_q[1];
  assign sck_rise = ~sck_prev_q &  sck_s2_q;
  assign sck_fall =  sck_prev_q & ~sck_s2_q;

  // Transfer state
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       ms_q, ms_d;
  logic [5:0] addr_q, addr_d;
  logic       miso_q, miso_d;
  logic       armed_q, armed_d;
  logic       pend_q, pend_d;
  logic       wr_strobe_q;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [7:0] regs_q [DEPTH];
  logic [7:0] regs_d [DEPTH];

  logic [7:0] rx_next;
  logic [5:0] addr_inc;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       spi_we;
  logic [5:0] spi_waddr;
  logic [7:0] spi_wdata;

  assign rx_next   = {rx_q[6:0], mosi_s2_q};
  assign addr_inc  = ms_q ? 6'(addr_q + 6'd1) : addr_q;
  // In CMD the address comes straight from the byte being completed; in
  // DATA it is the address of the next byte of the burst.
  assign rd_addr   = (state_q == CMD) ? rx_next[5:0] : addr_inc;
  assign spi_waddr = addr_q;
  assign spi_wdata = rx_next;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr == 6'(i)) rd_data = regs_q[i];
    end
    if (WHOAMI_EN && rd_addr == 6'h0F) rd_data = WHOAMI_VAL;
  end

  // SPI write takes priority over a local update to the same register.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (spi_we && spi_waddr == 6'(i)) begin
        if (!(WHOAMI_EN && i == 32'd15)) regs_d[i] = spi_wdata;
      end else if (upd_en && upd_addr == 6'(i)) begin
        if (!(WHOAMI_EN && i == 32'd15)) regs_d[i] = upd_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    ms_d      = ms_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    armed_d   = armed_q;
    pend_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    spi_we    = 1'b0;

    // A new transfer needs csn to have been seen high first, so a reset
    // in the middle of a transfer does not restart on the same select.
    if (sync_vld && csn_sync) armed_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!csn_sync && armed_q) begin
          state_d = CMD;
          cnt_d   = '0;
          rx_d    = '0;
          armed_d = 1'b0;
        end
      end

      CMD: begin
        miso_d = 1'b0;
        if (csn_sync) begin
          state_d = IDLE;
        end else if (sck_rise) begin
          rx_d  = rx_next;
          cnt_d = 3'(cnt_q + 3'd1);
          if (cnt_q == 3'd7) begin
            rw_d    = rx_next[7];
            ms_d    = rx_next[6];
            addr_d  = rx_next[5:0];
            tx_d    = rx_next[7] ? rd_data : '0;
            state_d = DATA;
            cnt_d   = '0;
          end
        end
      end

      DATA: begin
        if (csn_sync) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else if (rw_q) begin
          if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sck_rise) begin
            cnt_d = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'd7) begin
              addr_d = addr_inc;
              tx_d   = rd_data;
            end
          end
        end else begin
          miso_d = 1'b0;
          if (sck_rise) begin
            rx_d  = rx_next;
            cnt_d = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'd7) begin
              spi_we    = 1'b1;
              pend_d    = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rx_next;
              addr_d    = addr_inc;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      ms_q        <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      armed_q     <= 1'b0;
      pend_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      ms_q        <= ms_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      wr_strobe_q <= pend_q;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = ~csn_sync;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
